alu_cmd_sequencer: RTL and testbench

- Command-level controller for the 8-bit accumulator ALU (AND/OR/NOT/XOR/ADD/SUB/MULT with MULT overflow flag).
- Buffers operation requests in a small queue and drives the ALU operand, input-select and one-hot output-select controls for each command.
- Waits out the ALU register latency, captures result and overflow, and returns them over a valid/ready response channel.
- Owns the OFF/READY/RUN/ERROR sequencing, so the ALU itself carries no control logic.

---
 rtl/alu_cmd_sequencer_if.sv | 24 ++
 rtl/alu_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels between a requester (master) and
// alu_cmd_sequencer (slave).
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_chain;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command-level controller for the 8-bit accumulator ALU: queues requests, drives
// the ALU operand/select controls, waits out its latency and returns the result.
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    on,
    alu_cmd_sequencer_if.slave      bus,
    output logic [7:0]              alu_num1,
    output logic [7:0]              alu_num2,
    output logic [2:0]              alu_in_sel,
    output logic [6:0]              alu_out_sel,
    input  logic [7:0]              alu_result,
    input  logic                    alu_ovf,
    output logic                    err_sticky,
    input  logic                    err_clr,
    output logic [2:0]              state,
    output logic [$clog2(DEPTH):0]  q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam logic [PW:0] QFULL = (PW + 1)'(DEPTH);

    localparam logic [2:0] IN_CLEAR   = 3'b001;
    localparam logic [2:0] IN_LOAD    = 3'b010;
    localparam logic [2:0] IN_PERSIST = 3'b100;
    localparam logic [2:0] OP_MULT    = 3'd6;
    localparam logic [2:0] OP_CLR     = 3'd7;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        READY = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4,
        ERROR = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic       chain;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    state_t          fsm;
    cmd_t            mem [DEPTH];
    cmd_t            head;
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [2:0]      workOp;
    logic [CW-1:0]   waitCnt;
    logic [7:0]      accum;
    logic [6:0]      headHot;
    logic            push;
    logic            pop;
    logic            lastWait;
    logic            captureErr;
    logic            errSet;

    assign state         = fsm;
    assign head          = mem[rdPtr];
    assign bus.cmd_ready = (q_count < QFULL) && (fsm != OFF);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    // Uses the registered count, so an entry pushed into an empty queue pops next cycle.
    assign pop           = (fsm == READY) && on && (q_count != '0);
    assign lastWait      = (fsm == WAIT) && (waitCnt == CW'(1));
    assign captureErr    = alu_ovf && (workOp == OP_MULT);
    assign errSet        = lastWait && captureErr;

    // One-hot output select: op 0 (AND) maps to bit 6 down to op 6 (MULT) at bit 0; CLR selects nothing.
    for (genvar gi = 0; gi < 7; gi++) begin : g_hot
        assign headHot[gi] = (head.op == 3'(6 - gi));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= {bus.cmd_op, bus.cmd_chain, bus.cmd_a, bus.cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm           <= OFF;
            wrPtr         <= '0;
            rdPtr         <= '0;
            q_count       <= '0;
            workOp        <= '0;
            waitCnt       <= '0;
            accum         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            err_sticky    <= 1'b0;
            alu_in_sel    <= IN_CLEAR;
            alu_out_sel   <= '0;
            alu_num1      <= '0;
            alu_num2      <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            q_count    <= q_count + (PW + 1)'(push) - (PW + 1)'(pop);
            err_sticky <= errSet | (err_sticky & ~err_clr);

            case (fsm)
                OFF: begin
                    if (on) begin
                        fsm <= READY;
                    end
                end
                READY: begin
                    if (!on) begin
                        fsm <= OFF;
                    end else if (pop) begin
                        workOp      <= head.op;
                        alu_in_sel  <= IN_LOAD;
                        alu_num1    <= head.chain ? accum : head.a;
                        alu_num2    <= head.b;
                        alu_out_sel <= headHot;
                        fsm         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (workOp == OP_CLR) begin
                        accum         <= '0;
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        alu_in_sel    <= IN_CLEAR;
                        alu_out_sel   <= '0;
                        fsm           <= RESP;
                    end else begin
                        waitCnt    <= CW'(ALU_LAT);
                        alu_in_sel <= IN_PERSIST;
                        fsm        <= WAIT;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - CW'(1);
                    if (lastWait) begin
                        accum         <= alu_result;
                        bus.rsp_data  <= alu_result;
                        bus.rsp_err   <= captureErr;
                        bus.rsp_valid <= 1'b1;
                        alu_in_sel    <= IN_CLEAR;
                        alu_out_sel   <= '0;
                        fsm           <= RESP;
                    end
                end
                RESP: begin
                    // Dropping 'on' here is deliberately ignored; OFF is entered from READY.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        fsm           <= bus.rsp_err ? ERROR : READY;
                    end
                end
                ERROR: begin
                    fsm <= READY;
                end
                default: begin
                    fsm <= OFF;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer with a behavioural ALU
// and a command-level reference model.
module tb_alu_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       on = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] alu_num1;
    logic [7:0] alu_num2;
    logic [2:0] alu_in_sel;
    logic [6:0] alu_out_sel;
    logic [7:0] aluRes = 8'h00;
    logic       aluOvf = 1'b0;
    logic       err_sticky;
    logic [2:0] state;
    logic [$clog2(DEPTH):0] q_count;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .on          (on),
        .bus         (bus),
        .alu_num1    (alu_num1),
        .alu_num2    (alu_num2),
        .alu_in_sel  (alu_in_sel),
        .alu_out_sel (alu_out_sel),
        .alu_result  (aluRes),
        .alu_ovf     (aluOvf),
        .err_sticky  (err_sticky),
        .err_clr     (err_clr),
        .state       (state),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    typedef struct { int op; int chain; int a; int b; } cmd_s;
    typedef struct { int op; int numA; int numB; int res; int err; } exp_s;

    cmd_s srcQ[$];
    exp_s issueQ[$];
    exp_s rspQ[$];
    int   accModel = 0;
    int   stickyModel = 0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   issueCyc = 0;
    int   issueOp = 0;
    int   issueSel = 0;
    int   errPhase = 0;
    int   prevRspValid = 0;
    int   maxQ = 0;
    int   validPct = 100;
    int   readyPct = 100;

    task automatic checkEq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Command semantics on plain integers, 8-bit truncated.
    function automatic int refAlu(input int op, input int a, input int b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return (~a) & 255;
            3: return a ^ b;
            4: return (a + b) % 256;
            5: return (a - b + 256) % 256;
            6: return (a * b) % 256;
            default: return 0;
        endcase
    endfunction

    function automatic int opFromSel(input logic [6:0] sel);
        int op = 7;
        for (int k = 0; k < 7; k++) begin
            if (int'(sel) == (64 >> k)) op = k;
        end
        return op;
    endfunction

    // Behavioural ALU: operand registers load on the edge that ends a load cycle;
    // the multiply overflow flag is raised regardless of the output select.
    always @(posedge clk) begin
        if (alu_in_sel[1]) begin
            aluRes <= 8'(refAlu(opFromSel(alu_out_sel), int'(alu_num1), int'(alu_num2)));
            aluOvf <= (int'(alu_num1) * int'(alu_num2)) > 255;
        end
    end

    task automatic addCmd(input int op, input int chain, input int a, input int b);
        cmd_s c;
        c.op = op; c.chain = chain; c.a = a; c.b = b;
        srcQ.push_back(c);
    endtask

    // One clock: observe at the falling edge, then drive inputs for the next rising edge.
    task automatic cycle();
        exp_s e;
        cmd_s c;
        @(negedge clk);
        cyc++;
        if (state == 3'd2) begin
            if (issueQ.size() == 0) begin
                checkEq("issue_unexpected", 1, 0);
            end else begin
                e = issueQ.pop_front();
                checkEq("issue_in_sel", int'(alu_in_sel), 2);
                checkEq("issue_num1", int'(alu_num1), e.numA);
                checkEq("issue_num2", int'(alu_num2), e.numB);
                checkEq("issue_out_sel", int'(alu_out_sel), (e.op == 7) ? 0 : (64 >> e.op));
                issueCyc = cyc;
                issueOp = e.op;
                issueSel = (e.op == 7) ? 0 : (64 >> e.op);
            end
        end
        if (state == 3'd3) begin
            checkEq("wait_in_sel", int'(alu_in_sel), 4);
            checkEq("wait_out_sel", int'(alu_out_sel), issueSel);
        end
        checkEq("q_count", int'(q_count), issueQ.size());
        checkEq("cmd_ready", int'(bus.cmd_ready), int'(issueQ.size() < DEPTH && state != 3'd0));
        if (int'(q_count) > maxQ) maxQ = int'(q_count);
        if (errPhase == 1) begin
            checkEq("state_error", int'(state), 5);
            errPhase = 2;
        end else if (errPhase == 2) begin
            checkEq("state_after_error", int'(state), 1);
            errPhase = 0;
        end
        if (bus.rsp_valid && prevRspValid == 0)
            checkEq("rsp_latency", cyc - issueCyc, (issueOp == 7) ? 1 : ALU_LAT + 1);
        prevRspValid = int'(bus.rsp_valid);
        if (bus.rsp_valid) begin
            if (rspQ.size() == 0) begin
                checkEq("rsp_unexpected", 1, 0);
            end else begin
                checkEq("rsp_data", int'(bus.rsp_data), rspQ[0].res);
                checkEq("rsp_err", int'(bus.rsp_err), rspQ[0].err);
            end
        end

        bus.cmd_valid = 1'b0;
        if (srcQ.size() > 0 && $urandom_range(99) < validPct) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 3'(srcQ[0].op);
            bus.cmd_chain = 1'(srcQ[0].chain);
            bus.cmd_a     = 8'(srcQ[0].a);
            bus.cmd_b     = 8'(srcQ[0].b);
        end
        bus.rsp_ready = ($urandom_range(99) < readyPct);

        if (bus.cmd_valid && bus.cmd_ready) begin
            c = srcQ.pop_front();
            e.op   = c.op;
            e.numA = c.chain ? accModel : c.a;
            e.numB = c.b;
            if (c.op == 7) begin
                e.res = 0;
                e.err = 0;
            end else begin
                e.res = refAlu(c.op, e.numA, c.b);
                e.err = int'(c.op == 6 && e.numA * c.b > 255);
            end
            accModel = e.res;
            issueQ.push_back(e);
            rspQ.push_back(e);
        end
        if (bus.rsp_valid && bus.rsp_ready && rspQ.size() > 0) begin
            e = rspQ.pop_front();
            if (e.err != 0) begin
                stickyModel = 1;
                errPhase = 1;
            end
            checkEq("err_sticky", int'(err_sticky), stickyModel);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((srcQ.size() > 0 || rspQ.size() > 0 || state != 3'd1) && n < budget) begin
            cycle();
            n++;
        end
        checkEq("drain_timeout", int'(n < budget), 1);
    endtask

    task automatic waitState(input int s, input int budget);
        int n = 0;
        while (int'(state) != s && n < budget) begin
            cycle();
            n++;
        end
        checkEq("wait_state_timeout", int'(n < budget), 1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_chain = 1'b0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkEq("rst_state", int'(state), 0);
        checkEq("rst_q_count", int'(q_count), 0);
        checkEq("rst_rsp_valid", int'(bus.rsp_valid), 0);
        checkEq("rst_rsp_data", int'(bus.rsp_data), 0);
        checkEq("rst_rsp_err", int'(bus.rsp_err), 0);
        checkEq("rst_err_sticky", int'(err_sticky), 0);
        checkEq("rst_in_sel", int'(alu_in_sel), 1);
        checkEq("rst_out_sel", int'(alu_out_sel), 0);
        checkEq("rst_num1", int'(alu_num1), 0);
        checkEq("rst_num2", int'(alu_num2), 0);
        checkEq("rst_cmd_ready", int'(bus.cmd_ready), 0);
        rst = 1'b1;

        // Single ADD, then MULT overflow with sticky error and clear.
        on = 1'b1;
        cycle();
        checkEq("off_to_ready", int'(state), 1);
        addCmd(4, 0, 8'h12, 8'h34);
        drain(50);
        addCmd(6, 0, 8'h20, 8'h10);
        drain(50);
        checkEq("sticky_after_mult", int'(err_sticky), 1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        stickyModel = 0;
        cycle();
        checkEq("sticky_cleared", int'(err_sticky), 0);

        // Chaining through the accumulator, CLR, and ovf gating on a non-MULT op.
        addCmd(4, 0, 8'h05, 8'h03);
        addCmd(5, 1, 8'hAA, 8'h02);
        addCmd(7, 0, 8'h55, 8'h66);
        addCmd(4, 1, 8'hCC, 8'h01);
        addCmd(4, 0, 8'hF0, 8'hF0);
        drain(100);
        checkEq("no_err_on_add", int'(err_sticky), 0);

        // Response stall fills the queue and blocks the sixth command.
        readyPct = 0;
        for (int i = 0; i < 6; i++) addCmd(i % 6, 0, 8'h10 + i, 8'h03);
        repeat (12) cycle();
        checkEq("full_q_count", int'(q_count), DEPTH);
        checkEq("full_cmd_ready", int'(bus.cmd_ready), 0);
        checkEq("full_blocked", srcQ.size(), 1);
        readyPct = 100;
        drain(100);

        // 'on' dropped in WAIT: response delivered, then OFF with the queue retained.
        addCmd(4, 0, 8'h01, 8'h02);
        addCmd(1, 0, 8'h0F, 8'hF0);
        addCmd(3, 1, 8'h00, 8'hFF);
        waitState(3, 20);
        on = 1'b0;
        waitState(0, 20);
        repeat (3) cycle();
        checkEq("off_state", int'(state), 0);
        checkEq("off_cmd_ready", int'(bus.cmd_ready), 0);
        checkEq("off_retained", int'(q_count), 2);
        checkEq("off_rsp_pending", rspQ.size(), 2);
        on = 1'b1;
        drain(100);

        // Asynchronous reset in WAIT abandons everything.
        addCmd(6, 0, 8'h33, 8'h44);
        addCmd(4, 0, 8'h01, 8'h01);
        waitState(3, 20);
        #1 rst = 1'b0;
        #1;
        checkEq("mid_rst_state", int'(state), 0);
        checkEq("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
        checkEq("mid_rst_q_count", int'(q_count), 0);
        checkEq("mid_rst_in_sel", int'(alu_in_sel), 1);
        checkEq("mid_rst_out_sel", int'(alu_out_sel), 0);
        checkEq("mid_rst_num1", int'(alu_num1), 0);
        srcQ.delete();
        issueQ.delete();
        rspQ.delete();
        accModel = 0;
        stickyModel = 0;
        errPhase = 0;
        prevRspValid = 0;
        bus.cmd_valid = 1'b0;
        #1 rst = 1'b1;
        checkEq("post_rst_state", int'(state), 0);
        checkEq("post_rst_q_count", int'(q_count), 0);
        cycle();

        // Random traffic with random valid and ready pacing.
        validPct = 60;
        readyPct = 70;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0)
                addCmd(int'($urandom_range(7)), int'($urandom_range(1)),
                       int'($urandom_range(15)), int'($urandom_range(15)));
            else
                addCmd(int'($urandom_range(7)), int'($urandom_range(1)),
                       int'($urandom_range(255)), int'($urandom_range(255)));
        end
        drain(8000);
        checkEq("max_q_count", int'(maxQ <= DEPTH), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end
endmodule
